// File: rtl/thread_scheduler_if.sv
// -----------------------------------------------------------------------------
// thread_scheduler_if
//
// Issue-side bundle between the thread scheduler and the operand-fetch stage.
//
//   pipeline_stall  fetch -> scheduler   downstream cannot accept an issue
//   ts_issue_valid  scheduler -> fetch   registered: an instruction issues
//   ts_thread_idx   scheduler -> fetch   registered selected thread
//   ts_thread_oh    scheduler -> fetch   one-hot of ts_thread_idx, zero if idle
//
// Modports: master = scheduler side, slave = operand-fetch side.
// -----------------------------------------------------------------------------
`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif

interface thread_scheduler_if #(
    parameter int NUM_THREADS = `THREADS_PER_CORE
);
    localparam int IDX_W = $clog2(NUM_THREADS);

    logic                   pipeline_stall;
    logic                   ts_issue_valid;
    logic [IDX_W-1:0]       ts_thread_idx;
    logic [NUM_THREADS-1:0] ts_thread_oh;

    modport master (
        input  pipeline_stall,
        output ts_issue_valid,
        output ts_thread_idx,
        output ts_thread_oh
    );

    modport slave (
        output pipeline_stall,
        input  ts_issue_valid,
        input  ts_thread_idx,
        input  ts_thread_oh
    );
endinterface

// File: rtl/thread_scheduler.sv
// -----------------------------------------------------------------------------
// thread_scheduler
//
// Per-core issue scheduler. Tracks an IDLE/READY/SUSPENDED run state for each
// hardware thread and picks one runnable thread per cycle, round-robin, for
// the operand-fetch stage. The selection is registered and held under stall.
//
// Ports:
//   clk                  core clock
//   reset                asynchronous, active-high
//   issue_if (master)    pipeline_stall in; ts_issue_valid / ts_thread_idx /
//                        ts_thread_oh out (see thread_scheduler_if)
//   cr_thread_enable     per-thread enable from control registers
//   ifq_ready            per-thread instruction FIFO non-empty
//   suspend_en/_idx      dcache miss: suspend one thread
//   wake_bitmap          fill complete: wake these threads
//   rollback_en/_idx     rollback in progress for one thread
//   ts_suspended         per-thread SUSPENDED state
//   ts_starved           per-thread starvation watchdog flags
//
// Build option: define SCHED_WATCHDOG_EN to build the per-thread 8-bit
// starvation counters; otherwise ts_starved is tied to zero.
// -----------------------------------------------------------------------------
`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif

module thread_scheduler #(
    parameter int NUM_THREADS = `THREADS_PER_CORE,
    localparam int IDX_W      = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   reset,
    thread_scheduler_if.master     issue_if,
    input  logic [NUM_THREADS-1:0] cr_thread_enable,
    input  logic [NUM_THREADS-1:0] ifq_ready,
    input  logic                   suspend_en,
    input  logic [IDX_W-1:0]       suspend_thread_idx,
    input  logic [NUM_THREADS-1:0] wake_bitmap,
    input  logic                   rollback_en,
    input  logic [IDX_W-1:0]       rollback_thread_idx,
    output logic [NUM_THREADS-1:0] ts_suspended,
    output logic [NUM_THREADS-1:0] ts_starved
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READY     = 2'd1,
        ST_SUSPENDED = 2'd2
    } thread_state_e;

    thread_state_e          state_q [NUM_THREADS];
    thread_state_e          state_d [NUM_THREADS];

    logic [NUM_THREADS-1:0] suspend_vec;
    logic [NUM_THREADS-1:0] rollback_vec;
    logic [NUM_THREADS-1:0] ready_vec;
    logic [NUM_THREADS-1:0] candidates;

    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       probe_idx;
    logic [NUM_THREADS-1:0] sel_oh;

    logic                   valid_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_THREADS-1:0] oh_q;
    logic [IDX_W-1:0]       last_q;

    wire                    stall = issue_if.pipeline_stall;

    // Decode the indexed suspend/rollback requests into per-thread masks.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path can leave it unassigned and infer a latch.
    always_comb begin
        suspend_vec  = '0;
        rollback_vec = '0;
        if (suspend_en)  suspend_vec[suspend_thread_idx]   = 1'b1;
        if (rollback_en) rollback_vec[rollback_thread_idx] = 1'b1;
    end

    // Per-thread run-state FSM: next-state logic. Disable overrides all;
    // a suspend that coincides with a wake keeps the thread suspended.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            state_d[t] = state_q[t];
            if (!cr_thread_enable[t]) begin
                state_d[t] = ST_IDLE;
            end else begin
                unique case (state_q[t])
                    ST_IDLE:      state_d[t] = ST_READY;
                    ST_READY:     if (suspend_vec[t]) state_d[t] = ST_SUSPENDED;
                    ST_SUSPENDED: if (!suspend_vec[t] && wake_bitmap[t]) state_d[t] = ST_READY;
                    default:      state_d[t] = ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) state_q[t] <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ready_vec    = '0;
        ts_suspended = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            ready_vec[t]    = (state_q[t] == ST_READY);
            ts_suspended[t] = (state_q[t] == ST_SUSPENDED);
        end
    end

    // A thread being suspended or rolled back this cycle must not issue.
    assign candidates = ready_vec & ifq_ready & cr_thread_enable
                      & ~rollback_vec & ~suspend_vec;

    // Round-robin: first candidate at or after last_q+1. The index wraps
    // naturally because NUM_THREADS is a power of two.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        probe_idx = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            probe_idx = last_q + IDX_W'(i + 1);
            if (!sel_found && candidates[probe_idx]) begin
                sel_found = 1'b1;
                sel_idx   = probe_idx;
            end
        end
        sel_oh          = '0;
        sel_oh[sel_idx] = sel_found;
    end

    // Issue register. A stall freezes the selection and the round-robin
    // pointer, but a rollback of the held thread still withdraws the issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            oh_q    <= '0;
            last_q  <= IDX_W'(NUM_THREADS - 1);
        end else if (!stall) begin
            valid_q <= sel_found;
            oh_q    <= sel_oh;
            if (sel_found) begin
                idx_q  <= sel_idx;
                last_q <= sel_idx;
            end
        end else if (rollback_en && valid_q && (rollback_thread_idx == idx_q)) begin
            valid_q <= 1'b0;
            oh_q    <= '0;
        end
    end

    assign issue_if.ts_issue_valid = valid_q;
    assign issue_if.ts_thread_idx  = idx_q;
    assign issue_if.ts_thread_oh   = oh_q;

`ifdef SCHED_WATCHDOG_EN
    logic [7:0] starve_cnt_q [NUM_THREADS];

    // Counts non-stall cycles a thread was eligible but lost arbitration;
    // saturates at 255 and clears on issue or on leaving READY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) starve_cnt_q[t] <= 8'd0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if ((state_q[t] != ST_READY) ||
                    (!stall && sel_found && (sel_idx == IDX_W'(t)))) begin
                    starve_cnt_q[t] <= 8'd0;
                end else if (!stall && candidates[t] && (starve_cnt_q[t] != 8'hFF)) begin
                    starve_cnt_q[t] <= starve_cnt_q[t] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        ts_starved = '0;
        for (int t = 0; t < NUM_THREADS; t++) ts_starved[t] = (starve_cnt_q[t] == 8'hFF);
    end
`else
    assign ts_starved = '0;
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// -----------------------------------------------------------------------------
// tb_thread_scheduler
//
// Directed bench for thread_scheduler with a scoreboard: each stimulus step
// that should issue pushes the expected thread into exp_q; a monitor pops
// and compares on every accepted issue (valid and not stalled), sampling on
// the falling edge. Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_thread_scheduler;

    localparam int NT = 4;

    logic          clk;
    logic          reset;
    logic [NT-1:0] cr_thread_enable;
    logic [NT-1:0] ifq_ready;
    logic          suspend_en;
    logic [1:0]    suspend_thread_idx;
    logic [NT-1:0] wake_bitmap;
    logic          rollback_en;
    logic [1:0]    rollback_thread_idx;
    logic [NT-1:0] ts_suspended;
    logic [NT-1:0] ts_starved;

    thread_scheduler_if #(.NUM_THREADS(NT)) issue_if ();

    thread_scheduler #(.NUM_THREADS(NT)) dut (
        .clk                 (clk),
        .reset               (reset),
        .issue_if            (issue_if.master),
        .cr_thread_enable    (cr_thread_enable),
        .ifq_ready           (ifq_ready),
        .suspend_en          (suspend_en),
        .suspend_thread_idx  (suspend_thread_idx),
        .wake_bitmap         (wake_bitmap),
        .rollback_en         (rollback_en),
        .rollback_thread_idx (rollback_thread_idx),
        .ts_suspended        (ts_suspended),
        .ts_starved          (ts_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle whose edge is expected to register an issue for thread t.
    task automatic expect_step(input int t);
        exp_q.push_back(t);
        step();
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if (issue_if.ts_issue_valid && !issue_if.pipeline_stall) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_issue: got thread %0d, expected none (t=%0t)",
                             issue_if.ts_thread_idx, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("issue_idx", 32'(issue_if.ts_thread_idx), 32'(e));
                    check("issue_oh", 32'(issue_if.ts_thread_oh), 32'(1) << e);
                end
            end else if (!issue_if.ts_issue_valid) begin
                check("idle_oh_zero", 32'(issue_if.ts_thread_oh), 32'd0);
            end
        end
    end

    initial begin
        reset                   = 1'b1;
        cr_thread_enable        = '0;
        ifq_ready               = '0;
        suspend_en              = 1'b0;
        suspend_thread_idx      = '0;
        wake_bitmap             = '0;
        rollback_en             = 1'b0;
        rollback_thread_idx     = '0;
        issue_if.pipeline_stall = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_valid", 32'(issue_if.ts_issue_valid), 32'd0);
        check("rst_idx", 32'(issue_if.ts_thread_idx), 32'd0);
        check("rst_oh", 32'(issue_if.ts_thread_oh), 32'd0);
        check("rst_suspended", 32'(ts_suspended), 32'd0);
        check("rst_starved", 32'(ts_starved), 32'd0);

        // Single thread: READY at first edge, first issue at the second.
        cr_thread_enable = 4'b0001;
        ifq_ready        = 4'b0001;
        step();
        check("edge1_no_issue", 32'(issue_if.ts_issue_valid), 32'd0);
        expect_step(0);
        check("edge2_valid", 32'(issue_if.ts_issue_valid), 32'd1);
        repeat (3) expect_step(0);

        // All threads: 1..3 become READY this edge, thread 0 issues again.
        cr_thread_enable = 4'b1111;
        ifq_ready        = 4'b1111;
        expect_step(0);
        expect_step(1);
        expect_step(2);
        expect_step(3);
        expect_step(0);

        // Stall for three cycles: thread 0 stays held.
        issue_if.pipeline_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 32'(issue_if.ts_issue_valid), 32'd1);
            check("stall_idx", 32'(issue_if.ts_thread_idx), 32'd0);
        end
        issue_if.pipeline_stall = 1'b0;
        expect_step(1);
        expect_step(2);
        expect_step(3);

        // Suspend thread 2; it is excluded in the suspend cycle already.
        suspend_en         = 1'b1;
        suspend_thread_idx = 2'd2;
        expect_step(0);
        suspend_en = 1'b0;
        check("susp2", 32'(ts_suspended), 32'b0100);
        expect_step(1);
        expect_step(3);
        expect_step(0);
        expect_step(1);
        expect_step(3);

        // Wake thread 2: still suspended during the wake cycle.
        wake_bitmap = 4'b0100;
        expect_step(0);
        wake_bitmap = '0;
        check("wake2", 32'(ts_suspended), 32'b0000);
        expect_step(1);
        expect_step(2);
        expect_step(3);

        // Suspend and wake thread 1 together: suspend wins.
        suspend_en         = 1'b1;
        suspend_thread_idx = 2'd1;
        wake_bitmap        = 4'b0010;
        expect_step(0);
        suspend_en  = 1'b0;
        wake_bitmap = '0;
        check("susp_wake1", 32'(ts_suspended), 32'b0010);
        expect_step(2);
        expect_step(3);
        expect_step(0);
        expect_step(2);

        // Disable suspended thread 1: IDLE, and a later wake is ignored.
        cr_thread_enable = 4'b1101;
        expect_step(3);
        check("disable1_susp", 32'(ts_suspended), 32'b0000);
        wake_bitmap = 4'b0010;
        expect_step(0);
        wake_bitmap = '0;
        check("wake_idle1", 32'(ts_suspended), 32'b0000);
        expect_step(2);
        step();  // thread 3 registered here, then withdrawn by rollback

        // Rollback of the held thread 3 under stall withdraws the issue.
        issue_if.pipeline_stall = 1'b1;
        rollback_en             = 1'b1;
        rollback_thread_idx     = 2'd3;
        step();
        check("rollback_valid", 32'(issue_if.ts_issue_valid), 32'd0);
        check("rollback_oh", 32'(issue_if.ts_thread_oh), 32'd0);
        rollback_en             = 1'b0;
        issue_if.pipeline_stall = 1'b0;
        expect_step(0);

        // Rollback excludes thread 2 from arbitration without stall.
        rollback_en         = 1'b1;
        rollback_thread_idx = 2'd2;
        expect_step(3);
        rollback_en = 1'b0;
        expect_step(0);

        // No candidates: no issue, and the pointer stays at thread 0.
        ifq_ready = '0;
        step();
        check("no_cand_valid", 32'(issue_if.ts_issue_valid), 32'd0);
        step();
        ifq_ready = 4'b1111;
        expect_step(2);
        ifq_ready = '0;
        step();
        step();
        check("queue_drained_1", 32'(exp_q.size()), 32'd0);

        // Reset in mid-operation clears everything immediately.
        ifq_ready          = 4'b1111;
        suspend_en         = 1'b1;
        suspend_thread_idx = 2'd3;
        step();
        reset      = 1'b1;
        suspend_en = 1'b0;
        #1;
        check("midrst_valid", 32'(issue_if.ts_issue_valid), 32'd0);
        check("midrst_oh", 32'(issue_if.ts_thread_oh), 32'd0);
        check("midrst_suspended", 32'(ts_suspended), 32'd0);
        step();
        reset = 1'b0;

        // Starve thread 1: it is eligible only in cycles where thread 0 wins.
        cr_thread_enable = 4'b1011;
        ifq_ready        = '0;
        step();
        step();
        for (int i = 0; i < 255; i++) begin
            ifq_ready = 4'b0011;
            expect_step(0);
`ifdef SCHED_WATCHDOG_EN
            if (i == 253) check("starved_at_254", 32'(ts_starved), 32'b0000);
            if (i == 254) check("starved_at_255", 32'(ts_starved), 32'b0010);
`endif
            ifq_ready = 4'b1000;
            expect_step(3);
        end
`ifdef SCHED_WATCHDOG_EN
        check("starved_held", 32'(ts_starved), 32'b0010);
`else
        check("starved_off", 32'(ts_starved), 32'b0000);
`endif
        ifq_ready = 4'b0010;
        expect_step(1);
        check("starved_cleared", 32'(ts_starved), 32'b0000);
        ifq_ready = '0;
        step();
        step();
        check("queue_drained_2", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
